register_bank_sb: RTL and testbench
===================================

REGISTER_BANK_SB -- requirements
Module: register_bank_sb

Interface
- REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  - DATA_W, 32, register width in bits.
  - ADDR_W, 4, address width; depth = 2**ADDR_W.
  - BYPASS, 1, 1 = write-to-read forwarding, 0 = none.
- REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
- REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
  - CLK, in, 1, clock; all state updates on the rising edge.
  - RST_N, in, 1, synchronous active-low reset.
  - RA, in, ADDR_W, read port A address.
  - RB, in, ADDR_W, read port B address.
  - PRA, out, DATA_W, read port A data.
  - PRB, out, DATA_W, read port B data.
  - WC, in, ADDR_W, write address.
  - WPC, in, DATA_W, write data.
  - W_RB, in, 1, write enable.
  - RSV, in, 1, reserve request (marks a register busy for a pending producer).
  - RSV_ADDR, in, ADDR_W, register to reserve.
  - RSV_ACK, out, 1, reserve accepted, combinational.
  - BUSY_A, out, 1, register RA is busy.
  - BUSY_B, out, 1, register RB is busy.
  - BUSY_CNT, out, ADDR_W+1, number of busy registers.

Function
- REQ-004 The bank SHALL hold 2**ADDR_W registers of DATA_W bits each.
- REQ-005 Writes: when W_RB=1 and RST_N=1, register WC SHALL take WPC on the rising edge; W_RB=0 leaves all registers unchanged.
- REQ-006 Reads SHALL be combinational: PRA = reg[RA], PRB = reg[RB]; RA=RB is legal and gives identical data.
- REQ-007 With BYPASS=1, when W_RB=1 and WC equals the read address, that port SHALL output WPC in the same cycle; with BYPASS=0 it SHALL output the stored value.
- REQ-008 The scoreboard SHALL hold one busy bit per register, all 0 out of reset.
- REQ-009 A reserve request (RSV=1) SHALL be accepted, with RSV_ACK=1, when busy[RSV_ADDR]=0 or when the same cycle's write clears it (W_RB=1, WC=RSV_ADDR).
- REQ-010 A reserve request SHALL be refused, with RSV_ACK=0 and no state change, when busy[RSV_ADDR]=1 and no write to RSV_ADDR occurs that cycle.
- REQ-011 RSV_ACK SHALL be 0 whenever RSV=0 or RST_N=0.
- REQ-012 Write-back clears busy: W_RB=1 SHALL set busy[WC]=0 at the edge, unless the same edge accepts a reservation of WC.
- REQ-013 Write and reserve to the same address in one cycle: the data SHALL be written, busy[WC] SHALL end at 1 (reserve wins), and BUSY_CNT SHALL be unchanged.
- REQ-014 A write to a non-busy register SHALL be legal, SHALL store the data, and SHALL leave the busy bits unchanged.
- REQ-015 BUSY_A SHALL equal busy[RA] and BUSY_B SHALL equal busy[RB], registered state only, with no same-cycle bypass.
- REQ-016 BUSY_CNT SHALL be a registered counter.
  - +1 on an accepted reserve of a non-busy register.
  - -1 on a write that clears a busy bit.
  - Net 0 when both happen on different addresses in the same cycle.
  - It SHALL always equal the popcount of the busy bits and SHALL never exceed 2**ADDR_W.
- REQ-017 Full condition: with all registers busy, BUSY_CNT=2**ADDR_W and every reserve SHALL be refused unless the same cycle writes that address.
- REQ-018 Out-of-range addresses cannot occur, since addresses are exactly ADDR_W bits; no wrap handling is required.

Reset
- REQ-019 While RST_N=0 at a rising edge, all registers SHALL become 0, all busy bits 0 and BUSY_CNT 0; W_RB and RSV SHALL be ignored.
- REQ-020 After reset: PRA=PRB=0 (with W_RB=0), BUSY_A=BUSY_B=0, RSV_ACK=0 until RSV is asserted with RST_N=1.
- REQ-021 Reset asserted with reservations pending SHALL discard them; a later write-back to a formerly busy register SHALL be a plain write (REQ-014).
- REQ-022 Before the first clock edge with RST_N=0, register contents are not required to be defined.

Verification
- REQ-023 Fill and read: reset; write reg[i]=i for i=0..15, one per cycle; read pairs (0,1)..(14,15) -> PRA=even index, PRB=odd index.
- REQ-024 Bypass: reg[3]=0x0; W_RB=1, WC=3, WPC=0xDEADBEEF, RA=3 in the same cycle -> PRA=0xDEADBEEF before the edge with BYPASS=1, PRA=0 before the edge with BYPASS=0.
- REQ-025 Scoreboard: reserve 5 -> RSV_ACK=1; next cycle BUSY_A=1 (RA=5), BUSY_CNT=1; reserve 5 again -> RSV_ACK=0, BUSY_CNT=1; write 5=0x55 -> BUSY_CNT=0, PRA=0x55.
- REQ-026 Same-cycle write and reserve of 7, with 7 busy -> RSV_ACK=1, reg[7]=WPC, busy[7]=1, BUSY_CNT unchanged.
- REQ-027 Full: reserve all 16 -> BUSY_CNT=16; reserve 0 -> RSV_ACK=0; write 0 while reserving 0 -> RSV_ACK=1, BUSY_CNT=16.
- REQ-028 Reset mid-operation: 3 registers busy with nonzero data; RST_N=0 for one edge -> BUSY_CNT=0, all reads 0, BUSY_A=BUSY_B=0.

Source files
------------

// File: rtl/register_bank_sb.sv
// Register bank with two combinational read ports, one write port with optional
// write-to-read forwarding, and a busy scoreboard for pending-producer tracking.
module register_bank_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] PRA,
    output logic [DATA_W-1:0] PRB,
    input  logic [ADDR_W-1:0] WC,
    input  logic [DATA_W-1:0] WPC,
    input  logic              W_RB,
    input  logic              RSV,
    input  logic [ADDR_W-1:0] RSV_ADDR,
    output logic              RSV_ACK,
    output logic              BUSY_A,
    output logic              BUSY_B,
    output logic [ADDR_W:0]   BUSY_CNT
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   busy_cnt_q;
    logic              wr_en;
    logic              cnt_inc;
    logic              cnt_dec;

    assign wr_en = RST_N && W_RB;

    // A busy register can still be reserved when this cycle's write releases it.
    assign RSV_ACK = RST_N && RSV && (!busy[RSV_ADDR] || (W_RB && (WC == RSV_ADDR)));

    // Same-address write+reserve on a busy register leaves the count unchanged.
    assign cnt_inc = RSV_ACK && !busy[RSV_ADDR];
    assign cnt_dec = wr_en && busy[WC] && !(RSV_ACK && (RSV_ADDR == WC));

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[WC] = 1'b0;
        end
        if (RSV_ACK) begin
            busy_next[RSV_ADDR] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the register
    // array is cleared on reset because post-reset reads must return zero.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (W_RB) begin
                regs[WC] <= WPC;
            end
            busy       <= busy_next;
            busy_cnt_q <= busy_cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
        end
    end

    assign PRA = (BYPASS && wr_en && (WC == RA)) ? WPC : regs[RA];
    assign PRB = (BYPASS && wr_en && (WC == RB)) ? WPC : regs[RB];

    assign BUSY_A   = busy[RA];
    assign BUSY_B   = busy[RB];
    assign BUSY_CNT = busy_cnt_q;

endmodule

// File: tb/tb_register_bank_sb.sv
// Scoreboard bench for register_bank_sb: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them against a forwarding and a non-forwarding bank.
module tb_register_bank_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    localparam logic [7:0] M_PA  = 8'h01;
    localparam logic [7:0] M_PB  = 8'h02;
    localparam logic [7:0] M_NA  = 8'h04;
    localparam logic [7:0] M_NB  = 8'h08;
    localparam logic [7:0] M_ACK = 8'h10;
    localparam logic [7:0] M_BA  = 8'h20;
    localparam logic [7:0] M_BB  = 8'h40;
    localparam logic [7:0] M_CNT = 8'h80;

    typedef struct {
        string       name;
        logic [7:0]  mask;
        logic [31:0] pra;
        logic [31:0] prb;
        logic [31:0] pra_nb;
        logic [31:0] prb_nb;
        logic        ack;
        logic        busy_a;
        logic        busy_b;
        logic [4:0]  cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] ra, rb, wc, rsv_addr;
    logic [DATA_W-1:0] wpc;
    logic              w_rb, rsv;

    logic [DATA_W-1:0] pra, prb, pra_nb, prb_nb;
    logic              ack, busy_a, busy_b;
    logic              ack_nb, busy_a_nb, busy_b_nb;
    logic [ADDR_W:0]   cnt, cnt_nb;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    register_bank_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1)) dut (
        .CLK(clk), .RST_N(rst_n), .RA(ra), .RB(rb), .PRA(pra), .PRB(prb),
        .WC(wc), .WPC(wpc), .W_RB(w_rb), .RSV(rsv), .RSV_ADDR(rsv_addr),
        .RSV_ACK(ack), .BUSY_A(busy_a), .BUSY_B(busy_b), .BUSY_CNT(cnt)
    );

    register_bank_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) dut_nb (
        .CLK(clk), .RST_N(rst_n), .RA(ra), .RB(rb), .PRA(pra_nb), .PRB(prb_nb),
        .WC(wc), .WPC(wpc), .W_RB(w_rb), .RSV(rsv), .RSV_ADDR(rsv_addr),
        .RSV_ACK(ack_nb), .BUSY_A(busy_a_nb), .BUSY_B(busy_b_nb), .BUSY_CNT(cnt_nb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: consumes every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.mask & M_PA)  check({e.name, ".pra"},    pra,    e.pra);
            if (e.mask & M_PB)  check({e.name, ".prb"},    prb,    e.prb);
            if (e.mask & M_NA)  check({e.name, ".pra_nb"}, pra_nb, e.pra_nb);
            if (e.mask & M_NB)  check({e.name, ".prb_nb"}, prb_nb, e.prb_nb);
            if (e.mask & M_ACK) begin
                check({e.name, ".ack"},    {31'd0, ack},    {31'd0, e.ack});
                check({e.name, ".ack_nb"}, {31'd0, ack_nb}, {31'd0, e.ack});
            end
            if (e.mask & M_BA)  check({e.name, ".busy_a"}, {31'd0, busy_a}, {31'd0, e.busy_a});
            if (e.mask & M_BB)  check({e.name, ".busy_b"}, {31'd0, busy_b}, {31'd0, e.busy_b});
            if (e.mask & M_CNT) begin
                check({e.name, ".cnt"},    {27'd0, cnt},    {27'd0, e.cnt});
                check({e.name, ".cnt_nb"}, {27'd0, cnt_nb}, {27'd0, e.cnt});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rn, input logic w, input int w_addr, input logic [31:0] w_data,
                         input logic r, input int r_addr, input int a, input int b);
        rst_n    = rn;
        w_rb     = w;
        wc       = ADDR_W'(w_addr);
        wpc      = w_data;
        rsv      = r;
        rsv_addr = ADDR_W'(r_addr);
        ra       = ADDR_W'(a);
        rb       = ADDR_W'(b);
    endtask

    task automatic push(input string name, input logic [7:0] mask,
                        input logic [31:0] pa, input logic [31:0] pb,
                        input logic [31:0] na, input logic [31:0] nb,
                        input logic k, input logic ba, input logic bb, input int c);
        exp_t e;
        e.name = name; e.mask = mask;
        e.pra = pa; e.prb = pb; e.pra_nb = na; e.prb_nb = nb;
        e.ack = k; e.busy_a = ba; e.busy_b = bb; e.cnt = 5'(c);
        exp_q.push_back(e);
    endtask

    // Read data identical on both banks.
    task automatic exp_rd(input string name, input logic [31:0] pa, input logic [31:0] pb);
        push(name, M_PA | M_PB | M_NA | M_NB, pa, pb, pa, pb, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic exp_sb(input string name, input logic k, input logic ba, input logic bb, input int c);
        push(name, M_ACK | M_BA | M_BB | M_CNT, '0, '0, '0, '0, k, ba, bb, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 1'b1, 1, 32'h1234, 1'b1, 2, 0, 1);
        step();
        exp_sb("rst_ack", 1'b0, 1'b0, 1'b0, 0);
        step();

        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1);
        exp_rd("post_rst_rd", 32'h0, 32'h0);
        exp_sb("post_rst_sb", 1'b0, 1'b0, 1'b0, 0);
        step();

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, i, 32'(i), 1'b0, 0, 0, 1);
            step();
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 2 * k, 2 * k + 1);
            exp_rd($sformatf("fill_%0d", k), 32'(2 * k), 32'(2 * k + 1));
            step();
        end

        // Forwarding versus stored value in the same cycle as the write.
        drive(1'b1, 1'b1, 3, 32'h0, 1'b0, 0, 3, 4);
        step();
        drive(1'b1, 1'b1, 3, 32'hDEADBEEF, 1'b0, 0, 3, 4);
        push("bypass", M_PA | M_PB | M_NA | M_NB, 32'hDEADBEEF, 32'h4, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 0);
        step();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 3, 3);
        exp_rd("bypass_after", 32'hDEADBEEF, 32'hDEADBEEF);
        step();

        drive(1'b1, 1'b0, 0, 0, 1'b1, 5, 5, 6);
        exp_sb("rsv5", 1'b1, 1'b0, 1'b0, 0);
        step();
        drive(1'b1, 1'b0, 0, 0, 1'b1, 5, 5, 6);
        exp_sb("rsv5_again", 1'b0, 1'b1, 1'b0, 1);
        step();
        drive(1'b1, 1'b1, 5, 32'h55, 1'b0, 0, 5, 6);
        push("wr5", M_PA | M_NA | M_BA | M_CNT, 32'h55, '0, 32'h5, '0, 1'b0, 1'b1, 1'b0, 1);
        step();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 5, 6);
        exp_rd("wr5_rd", 32'h55, 32'h6);
        exp_sb("wr5_sb", 1'b0, 1'b0, 1'b0, 0);
        step();

        // Same-cycle write and reserve of a busy register.
        drive(1'b1, 1'b0, 0, 0, 1'b1, 7, 7, 0);
        step();
        drive(1'b1, 1'b1, 7, 32'h77, 1'b1, 7, 7, 0);
        exp_sb("wr_rsv7", 1'b1, 1'b1, 1'b0, 1);
        step();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 7, 0);
        exp_rd("wr_rsv7_rd", 32'h77, 32'h0);
        exp_sb("wr_rsv7_sb", 1'b0, 1'b1, 1'b0, 1);
        step();
        drive(1'b1, 1'b1, 7, 32'h70, 1'b0, 0, 7, 0);
        step();

        // Clear on one address while reserving another: net count change is zero.
        drive(1'b1, 1'b0, 0, 0, 1'b1, 2, 2, 9);
        step();
        drive(1'b1, 1'b1, 2, 32'h22, 1'b1, 9, 2, 9);
        exp_sb("wr2_rsv9", 1'b1, 1'b1, 1'b0, 1);
        step();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 2, 9);
        exp_rd("wr2_rsv9_rd", 32'h22, 32'h9);
        exp_sb("wr2_rsv9_sb", 1'b0, 1'b0, 1'b1, 1);
        step();
        drive(1'b1, 1'b1, 9, 32'h99, 1'b0, 0, 0, 0);
        step();

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 0, 0, 1'b1, i, 0, 15);
            exp_sb($sformatf("fill_rsv_%0d", i), 1'b1, (i > 0), 1'b0, i);
            step();
        end
        drive(1'b1, 1'b0, 0, 0, 1'b1, 0, 0, 15);
        exp_sb("full_refuse", 1'b0, 1'b1, 1'b1, 16);
        step();
        drive(1'b1, 1'b1, 0, 32'hA0, 1'b1, 0, 0, 15);
        exp_sb("full_wr_rsv", 1'b1, 1'b1, 1'b1, 16);
        step();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 15);
        exp_rd("full_rd", 32'hA0, 32'hF);
        exp_sb("full_after", 1'b0, 1'b1, 1'b1, 16);
        step();

        // Mid-operation reset with three registers busy.
        drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
        step();
        drive(1'b1, 1'b1, 1, 32'h101, 1'b0, 0, 0, 0);
        step();
        drive(1'b1, 1'b1, 2, 32'h202, 1'b1, 1, 0, 0);
        step();
        drive(1'b1, 1'b1, 3, 32'h303, 1'b1, 2, 0, 0);
        step();
        drive(1'b1, 1'b0, 0, 0, 1'b1, 3, 1, 2);
        exp_sb("pre_rst", 1'b1, 1'b1, 1'b1, 2);
        step();
        drive(1'b0, 1'b1, 1, 32'hBAD, 1'b1, 4, 1, 3);
        push("mid_rst_ack", M_ACK | M_CNT, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 3);
        step();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1, 2);
        exp_rd("rst_rd12", 32'h0, 32'h0);
        exp_sb("rst_sb12", 1'b0, 1'b0, 1'b0, 0);
        step();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 3, 4);
        exp_rd("rst_rd34", 32'h0, 32'h0);
        exp_sb("rst_sb34", 1'b0, 1'b0, 1'b0, 0);
        step();

        // Writes to non-busy registers store data and leave the scoreboard alone.
        drive(1'b1, 1'b0, 0, 0, 1'b1, 4, 1, 4);
        step();
        drive(1'b1, 1'b1, 1, 32'h11, 1'b0, 0, 1, 4);
        step();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1, 4);
        exp_rd("plain_wr_rd", 32'h11, 32'h0);
        exp_sb("plain_wr_sb", 1'b0, 1'b0, 1'b1, 1);
        step();

        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
